// File: rtl/serial_seq_tx.sv
// serial_seq_tx: latches a WIDTH-bit pattern on a start handshake and
// shifts it out MSB-first, one bit per clock, optionally repeating it
// back-to-back repeat_n extra times, then pulses done for one cycle.
// Every output comes straight from a flop.
module serial_seq_tx #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_n,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [RPT_W-1:0] rpt_q,   rpt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             done_q,  done_d;

  // The serial bit is the shift register MSB; the register is zeroed
  // whenever no pattern bit is being presented so out idles low.
  assign out       = shift_q[WIDTH-1];
  assign ready     = ready_q;
  assign out_valid = valid_q;
  assign done      = done_q;

  // Next-state and next-output computation for the transmit FSM.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    ready_d = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SHIFT;
          shift_d = pattern;
          hold_d  = pattern;
          rpt_d   = repeat_n;
          cnt_d   = {CNT_W{1'b0}};
          valid_d = 1'b1;
        end else begin
          ready_d = 1'b1;
          shift_d = {WIDTH{1'b0}};
        end
      end

      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          shift_d = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          rpt_d   = {RPT_W{1'b0}};
          ready_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (rpt_q != {RPT_W{1'b0}}) begin
            // Reload for the next repetition with no gap bit.
            rpt_d   = rpt_q - RPT_W'(1);
            shift_d = hold_q;
            valid_d = 1'b1;
          end else begin
            state_d = S_DONE;
            shift_d = {WIDTH{1'b0}};
            done_d  = 1'b1;
          end
        end else begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
          valid_d = 1'b1;
        end
      end

      S_DONE: begin
        // Single-cycle state; start here is dropped, abort changes nothing.
        state_d = S_IDLE;
        shift_d = {WIDTH{1'b0}};
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        shift_d = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        rpt_d   = {RPT_W{1'b0}};
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      shift_q <= {WIDTH{1'b0}};
      hold_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      rpt_q   <= {RPT_W{1'b0}};
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule
